rd_dpram_be: RTL and testbench

- Parametrised successor of the fixed 64x32 two-port register RAM used for the DSP/GPU register files.
- Depth, width and byte-lane count are parametrised; each port has per-byte write enables and a selectable read-during-write mode.
- Same-address write collisions resolve deterministically by a priority parameter.
- An optional hardware clear sequencer zeroes the array after reset, so register files start in a known state without firmware writes.

---
 rtl/rd_dpram_be.sv | 115 +++++++++++
 tb/tb_rd_dpram_be.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rd_dpram_be.sv
// Two-port register-file RAM with per-byte write enables, selectable read-during-write
// behaviour, deterministic same-address collision resolution and an optional post-reset clear.
module rd_dpram_be #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter int RDW_MODE       = 0,
  parameter int COLL_PRI       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  sys_clk,
  input  logic                  resetl,
  input  logic                  clka,
  input  logic                  nwea,
  input  logic [DATA_W/8-1:0]   bea,
  input  logic [ADDR_W-1:0]     aa,
  input  logic [DATA_W-1:0]     da,
  output logic [DATA_W-1:0]     qa,
  input  logic                  clkb,
  input  logic                  nweb,
  input  logic [DATA_W/8-1:0]   beb,
  input  logic [ADDR_W-1:0]     ab,
  input  logic [DATA_W-1:0]     db,
  output logic [DATA_W-1:0]     qb,
  output logic                  busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ready, wr_a, wr_b, same_addr, clr_wr;
  logic [NB-1:0]       lane_a, lane_b;
  logic [DATA_W-1:0]   old_a, old_b, new_a, new_b, rd_a, rd_b;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (&cnt) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = READY;
    endcase
  end

  assign busy      = (state == CLEAR);
  assign ready     = (state == READY);
  assign clr_wr    = resetl && (state == CLEAR);
  assign wr_a      = ready && clka && !nwea;
  assign wr_b      = ready && clkb && !nweb;
  assign same_addr = (aa == ab);

  // Lane ownership: at a shared address each lane is written by exactly one port.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < NB; i++) begin
      lane_a[i] = wr_a && bea[i] &&
                  !(same_addr && wr_b && beb[i] && (COLL_PRI != 0));
      lane_b[i] = wr_b && beb[i] &&
                  !(same_addr && wr_a && bea[i] && (COLL_PRI == 0));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (clr_wr) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (lane_a[i]) mem[aa][8*i +: 8] <= da[8*i +: 8];
        if (lane_b[i]) mem[ab][8*i +: 8] <= db[8*i +: 8];
      end
    end
  end

  // Post-write view of each read address, used when reads must see the stored result.
  always_comb begin
    old_a = mem[aa];
    old_b = mem[ab];
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (lane_a[i])              new_a[8*i +: 8] = da[8*i +: 8];
      if (lane_b[i] && same_addr) new_a[8*i +: 8] = db[8*i +: 8];
      if (lane_b[i])              new_b[8*i +: 8] = db[8*i +: 8];
      if (lane_a[i] && same_addr) new_b[8*i +: 8] = da[8*i +: 8];
    end
    rd_a = (RDW_MODE != 0) ? new_a : old_a;
    rd_b = (RDW_MODE != 0) ? new_b : old_b;
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      qa <= '0;
      qb <= '0;
    end else begin
      if (ready && clka) qa <= rd_a;
      if (ready && clkb) qb <= rd_b;
    end
  end

endmodule

// File: tb/tb_rd_dpram_be.sv
// Directed self-checking bench: a default 64x32 instance and a 16x16 instance with
// post-write reads and port-A collision priority, both sharing clock and reset.
module tb_rd_dpram_be;

  logic        sys_clk, resetl;
  logic        clka, nwea, clkb, nweb;
  logic [3:0]  bea, beb;
  logic [5:0]  aa, ab;
  logic [31:0] da, db, qa, qb;
  logic        busy;

  logic        clka_s, nwea_s, clkb_s, nweb_s;
  logic [1:0]  bea_s, beb_s;
  logic [3:0]  aa_s, ab_s;
  logic [15:0] da_s, db_s, qa_s, qb_s;
  logic        busy_s;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  rd_dpram_be dut (
    .sys_clk(sys_clk), .resetl(resetl),
    .clka(clka), .nwea(nwea), .bea(bea), .aa(aa), .da(da), .qa(qa),
    .clkb(clkb), .nweb(nweb), .beb(beb), .ab(ab), .db(db), .qb(qb),
    .busy(busy)
  );

  rd_dpram_be #(.ADDR_W(4), .DATA_W(16), .RDW_MODE(1), .COLL_PRI(0), .CLEAR_ON_RESET(1)) dut_s (
    .sys_clk(sys_clk), .resetl(resetl),
    .clka(clka_s), .nwea(nwea_s), .bea(bea_s), .aa(aa_s), .da(da_s), .qa(qa_s),
    .clkb(clkb_s), .nweb(nweb_s), .beb(beb_s), .ab(ab_s), .db(db_s), .qb(qb_s),
    .busy(busy_s)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          sm;
    bit          ca;
    bit          wa_n;
    logic [3:0]  bea;
    logic [5:0]  aa;
    logic [31:0] da;
    bit          cb;
    bit          wb_n;
    logic [3:0]  beb;
    logic [5:0]  ab;
    logic [31:0] db;
    logic [31:0] eqa;
    logic [31:0] eqb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit sm, bit ca, bit wa_n, logic [3:0] bea_v, logic [5:0] aa_v,
                              logic [31:0] da_v, bit cb, bit wb_n, logic [3:0] beb_v,
                              logic [5:0] ab_v, logic [31:0] db_v,
                              logic [31:0] eqa, logic [31:0] eqb);
    vec_t v;
    v.sm = sm; v.ca = ca; v.wa_n = wa_n; v.bea = bea_v; v.aa = aa_v; v.da = da_v;
    v.cb = cb; v.wb_n = wb_n; v.beb = beb_v; v.ab = ab_v; v.db = db_v;
    v.eqa = eqa; v.eqb = eqb;
    return v;
  endfunction

  task automatic idle_all();
    clka = 0; nwea = 1; bea = '0; aa = '0; da = '0;
    clkb = 0; nweb = 1; beb = '0; ab = '0; db = '0;
    clka_s = 0; nwea_s = 1; bea_s = '0; aa_s = '0; da_s = '0;
    clkb_s = 0; nweb_s = 1; beb_s = '0; ab_s = '0; db_s = '0;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one vector at a falling edge, let one rising edge sample it, compare at the next falling edge.
  task automatic apply_stimulus(input vec_t v, input string tag);
    idle_all();
    if (!v.sm) begin
      clka = v.ca; nwea = v.wa_n; bea = v.bea; aa = v.aa; da = v.da;
      clkb = v.cb; nweb = v.wb_n; beb = v.beb; ab = v.ab; db = v.db;
    end else begin
      clka_s = v.ca; nwea_s = v.wa_n; bea_s = v.bea[1:0]; aa_s = v.aa[3:0]; da_s = v.da[15:0];
      clkb_s = v.cb; nweb_s = v.wb_n; beb_s = v.beb[1:0]; ab_s = v.ab[3:0]; db_s = v.db[15:0];
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    if (!v.sm) begin
      check_output({tag, " qa"}, qa, v.eqa);
      check_output({tag, " qb"}, qb, v.eqb);
    end else begin
      check_output({tag, " qa_s"}, {16'h0, qa_s}, v.eqa);
      check_output({tag, " qb_s"}, {16'h0, qb_s}, v.eqb);
    end
    idle_all();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 200 && busy; k++) begin
      n++;
      @(negedge sys_clk);
    end
  endtask

  initial begin
    idle_all();
    resetl = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_output("reset qa", qa, 32'h0);
    check_output("reset qb", qb, 32'h0);
    check_output("reset busy", {31'h0, busy}, 32'h1);
    check_output("reset busy_s", {31'h0, busy_s}, 32'h1);

    // Writes presented throughout the clear must be ignored.
    clka = 1; nwea = 0; bea = 4'hF; aa = 6'd0; da = 32'hFFFF_FFFF;
    resetl = 1'b1;
    count_busy(busy_cnt);
    idle_all();
    check_output("clear busy cycles", busy_cnt, 64);
    check_output("qa held during clear", qa, 32'h0);
    check_output("busy_s done", {31'h0, busy_s}, 32'h0);

    for (int i = 0; i < 64; i++) begin
      clka = 1; nwea = 1; aa = 6'(i);
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_output($sformatf("clear read %0d", i), qa, 32'h0);
    end
    idle_all();

    vecs.push_back(mk(0,1,0,4'hF,6'd5, 32'h11223344, 0,1,4'h0,6'd0, 32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(0,1,0,4'h5,6'd5, 32'hAABBCCDD, 0,1,4'h0,6'd0, 32'h0,        32'h11223344, 32'h0));
    vecs.push_back(mk(0,1,1,4'h0,6'd5, 32'h0,        0,1,4'h0,6'd0, 32'h0,        32'h11BB33DD, 32'h0));
    vecs.push_back(mk(0,0,1,4'h0,6'd0, 32'h0,        1,1,4'h0,6'd5, 32'h0,        32'h11BB33DD, 32'h11BB33DD));
    vecs.push_back(mk(0,1,0,4'hF,6'd7, 32'h12345678, 0,1,4'h0,6'd0, 32'h0,        32'h0,        32'h11BB33DD));
    vecs.push_back(mk(0,1,0,4'hF,6'd7, 32'hCAFEBABE, 1,1,4'h0,6'd7, 32'h0,        32'h12345678, 32'h12345678));
    vecs.push_back(mk(0,1,1,4'h0,6'd7, 32'h0,        0,1,4'h0,6'd0, 32'h0,        32'hCAFEBABE, 32'h12345678));
    vecs.push_back(mk(0,1,0,4'hC,6'd9, 32'hAAAAAAAA, 1,0,4'h6,6'd9, 32'hBBBBBBBB, 32'h0,        32'h0));
    vecs.push_back(mk(0,1,1,4'h0,6'd9, 32'h0,        1,1,4'h0,6'd9, 32'h0,        32'hAABBBB00, 32'hAABBBB00));
    vecs.push_back(mk(0,1,0,4'hF,6'd12,32'h01020304, 1,0,4'hF,6'd13,32'h05060708, 32'h0,        32'h0));
    vecs.push_back(mk(0,1,1,4'h0,6'd13,32'h0,        1,1,4'h0,6'd12,32'h0,        32'h05060708, 32'h01020304));
    vecs.push_back(mk(0,1,0,4'h0,6'd12,32'hFFFFFFFF, 0,1,4'h0,6'd0, 32'h0,        32'h01020304, 32'h01020304));
    vecs.push_back(mk(0,0,0,4'hF,6'd12,32'hDEADDEAD, 1,1,4'h0,6'd13,32'h0,        32'h01020304, 32'h05060708));
    vecs.push_back(mk(0,1,1,4'h0,6'd12,32'h0,        0,1,4'h0,6'd0, 32'h0,        32'h01020304, 32'h05060708));
    vecs.push_back(mk(0,1,1,4'h0,6'd20,32'h0,        1,0,4'h3,6'd20,32'h0000FFEE, 32'h0,        32'h0));
    vecs.push_back(mk(0,1,1,4'h0,6'd20,32'h0,        0,1,4'h0,6'd0, 32'h0,        32'h0000FFEE, 32'h0));
    vecs.push_back(mk(1,1,0,4'h3,6'd15,32'h5678,     0,1,4'h0,6'd0, 32'h0,        32'h5678,     32'h0));
    vecs.push_back(mk(1,1,0,4'h3,6'd15,32'hBABE,     1,1,4'h0,6'd15,32'h0,        32'hBABE,     32'hBABE));
    vecs.push_back(mk(1,0,0,4'h3,6'd15,32'h1111,     0,1,4'h0,6'd0, 32'h0,        32'hBABE,     32'hBABE));
    vecs.push_back(mk(1,1,1,4'h0,6'd15,32'h0,        0,1,4'h0,6'd0, 32'h0,        32'hBABE,     32'hBABE));
    vecs.push_back(mk(1,1,0,4'h2,6'd3, 32'hAAAA,     1,0,4'h3,6'd3, 32'hBBBB,     32'hAABB,     32'hAABB));
    vecs.push_back(mk(1,1,1,4'h0,6'd3, 32'h0,        0,1,4'h0,6'd0, 32'h0,        32'hAABB,     32'hAABB));
    vecs.push_back(mk(1,1,0,4'h1,6'd3, 32'h00CC,     1,1,4'h0,6'd3, 32'h0,        32'hAACC,     32'hAACC));
    vecs.push_back(mk(1,1,1,4'h0,6'd0, 32'h0,        1,1,4'h0,6'd15,32'h0,        32'h0,        32'hBABE));
    vecs.push_back(mk(1,1,1,4'h0,6'd15,32'h0,        1,0,4'h2,6'd15,32'h0011,     32'h00BE,     32'h00BE));
    vecs.push_back(mk(1,1,0,4'h3,6'd7, 32'h1234,     1,0,4'h3,6'd7, 32'h5678,     32'h1234,     32'h1234));

    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a clear must restart it from entry 0.
    apply_stimulus(mk(0,1,0,4'hF,6'd10,32'hDEADBEEF, 0,1,4'h0,6'd0,32'h0, 32'h0, 32'h0), "seed");
    apply_stimulus(mk(0,1,1,4'h0,6'd10,32'h0, 0,1,4'h0,6'd0,32'h0, 32'hDEADBEEF, 32'h0), "seed rd");
    resetl = 1'b0;
    #1;
    check_output("async reset qa", qa, 32'h0);
    @(negedge sys_clk);
    resetl = 1'b1;
    repeat (30) @(negedge sys_clk);
    check_output("busy at cycle 30", {31'h0, busy}, 32'h1);
    clka = 1; nwea = 1; aa = 6'd10;
    clkb = 1; nweb = 1; ab = 6'd10;
    resetl = 1'b0;
    #1;
    check_output("mid reset qa", qa, 32'h0);
    check_output("mid reset qb", qb, 32'h0);
    repeat (3) begin
      @(negedge sys_clk);
      check_output("held reset qa", qa, 32'h0);
      check_output("held reset qb", qb, 32'h0);
      check_output("held reset busy", {31'h0, busy}, 32'h1);
    end
    idle_all();
    resetl = 1'b1;
    count_busy(busy_cnt);
    check_output("restart busy cycles", busy_cnt, 64);
    apply_stimulus(mk(0,1,1,4'h0,6'd10,32'h0, 1,1,4'h0,6'd10,32'h0, 32'h0, 32'h0), "addr10 cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
